aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10: number of rounds issued per block, legal range 1..15.
REQ-002 Parameter RLAT, default 2: enabled-cycle latency of the external round datapath, legal range 1..7.
REQ-003 Parameter ID_W, default 4: width of the block tag.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port in_valid, input, 1: a new block is offered.
REQ-007 Port in_ready, output, 1: the controller can accept a block.
REQ-008 Port in_state, input, [3:0][3:0][7:0]: plaintext block.
REQ-009 Port in_id, input, ID_W: tag travelling with the block.
REQ-010 Port rk_idx, output, 4: round-key index requested from the key store.
REQ-011 Port rk_data, input, [3:0][3:0][7:0]: round key for rk_idx, valid combinationally in the same cycle.
REQ-012 Port rnd_en, output, 1: enable to the round datapath flops.
REQ-013 Port rnd_state, output, [3:0][3:0][7:0]: state operand to the round datapath.
REQ-014 Port rnd_key, output, [3:0][3:0][7:0]: key operand to the round datapath.
REQ-015 Port rnd_result, input, [3:0][3:0][7:0]: round datapath output.
REQ-016 Ports out_valid (output, 1), out_ready (input, 1), out_state (output, [3:0][3:0][7:0]) and out_id (output, ID_W) SHALL form the result handshake.
REQ-017 Port busy, output, 1: asserted whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, CAP and DONE.
REQ-019 In IDLE, in_ready SHALL be 1, rk_idx SHALL be 0 and rnd_en SHALL be 0.
REQ-020 On in_valid&&in_ready, the controller SHALL latch cur = in_state ^ rk_data (key 0), latch in_id, set round=1, set lat_cnt=0 and enter RUN.
REQ-021 In RUN: rk_idx=round, rnd_en=1, rnd_state=cur, rnd_key=rk_data; these SHALL be held stable for exactly RLAT cycles (lat_cnt 0..RLAT-1), after which the FSM SHALL enter CAP.
REQ-022 In CAP: rnd_en=0 and cur<=rnd_result; if round==NR the FSM SHALL enter DONE, otherwise round++, lat_cnt=0 and return to RUN.
REQ-023 In DONE: out_valid=1, out_state=cur and out_id=the latched tag, all held stable until out_ready; on the handshake the FSM SHALL return to IDLE.
REQ-024 out_valid SHALL rise exactly NR*(RLAT+1) cycles after the accept edge (30 for the defaults).
REQ-025 in_valid outside IDLE SHALL be ignored: no back-to-back accept in the DONE handshake cycle, no overlap.
REQ-026 out_ready low SHALL stall in DONE indefinitely with no state change; out_ready outside DONE SHALL be ignored.
REQ-027 In all states other than RUN, rnd_state and rnd_key SHALL output 0.

Reset
REQ-028 On rst: state=IDLE, round=0, lat_cnt=0, cur=0, tag=0; out_valid=0, busy=0, rnd_en=0, in_ready=1 as soon as rst is deasserted.
REQ-029 Reset asserted mid-block SHALL discard the block and SHALL produce no out_valid for it.

Configuration
REQ-030 With AES_CTRL_STATS_EN defined, a 32-bit output blk_cnt SHALL count completed output handshakes, saturate at 0xFFFFFFFF and reset to 0.
REQ-031 Without AES_CTRL_STATS_EN, the blk_cnt port and its counter SHALL be absent, with all other behaviour unchanged.

Structure
REQ-032 Package aes_ctrl_pkg SHALL hold the block_t typedef (logic [3:0][3:0][7:0]), the ctrl_state_e enum, and the NR/RLAT default constants.
REQ-033 The out_state/out_id holding register SHALL be one floper instance of width 128+ID_W; all other flops SHALL be inline.

Verification
REQ-034 Stub round unit: rnd_result = rnd_state ^ rnd_key, registered RLAT deep on rnd_en; rk_data[i] = {16{8'(i)}}; in_state = 0x00112233_44556677_8899AABB_CCDDEEFF -> out_state = in_state ^ {16{8'h0B}}, out_valid exactly 30 cycles after accept.
REQ-035 Hold out_ready=0 for 20 cycles in DONE, pulsing in_valid -> out_state and out_id stable, in_ready=0, no second accept.
REQ-036 Two blocks with ids 3 then 9, out_ready=1 -> outputs in order 3 then 9, second accept no earlier than the cycle after the first output handshake.
REQ-037 Assert rst during round 5 -> busy=0, in_ready=1 next cycle, no out_valid; a following block completes correctly.
REQ-038 NR=1, RLAT=1 -> out_valid 2 cycles after accept, result = in_state ^ k0 ^ k1.
REQ-039 With AES_CTRL_STATS_EN, 3 completed blocks -> blk_cnt=3; a forced value of 0xFFFFFFFF stays saturated.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types and defaults for the AES round controller
package aes_ctrl_pkg;

    typedef logic [3:0][3:0][7:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAP,
        DONE
    } ctrl_state_e;

    localparam int NR_DEF   = 10;
    localparam int RLAT_DEF = 2;

endpackage

// File: rtl/aes_round_ctrl_floper.sv
// rtl/aes_round_ctrl_floper.sv - enabled register with asynchronous reset
module aes_round_ctrl_floper #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES round sequencer around an external round datapath; AES_CTRL_STATS_EN adds blk_cnt
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR   = NR_DEF,
    parameter int RLAT = RLAT_DEF,
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  block_t          in_state,
    input  logic [ID_W-1:0] in_id,
    output logic [3:0]      rk_idx,
    input  block_t          rk_data,
    output logic            rnd_en,
    output block_t          rnd_state,
    output block_t          rnd_key,
    input  block_t          rnd_result,
    output logic            out_valid,
    input  logic            out_ready,
    output block_t          out_state,
    output logic [ID_W-1:0] out_id,
    output logic            busy
`ifdef AES_CTRL_STATS_EN
    ,
    output logic [31:0]     blk_cnt
`endif
);

    localparam int HW = 128 + ID_W;

    ctrl_state_e     state, state_n;
    logic [3:0]      round;
    logic [2:0]      lat_cnt;
    block_t          cur;
    logic [ID_W-1:0] tag;
    logic            last_lat;
    logic            last_round;
    logic            hold_en;
    logic [HW-1:0]   hold_q;

    assign last_lat   = (lat_cnt == 3'(RLAT - 1));
    assign last_round = (round == 4'(NR));

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        rk_idx    = 4'd0;
        rnd_en    = 1'b0;
        rnd_state = '0;
        rnd_key   = '0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                rk_idx    = round;
                rnd_en    = 1'b1;
                rnd_state = cur;
                rnd_key   = rk_data;
                if (last_lat) state_n = CAP;
            end
            CAP: begin
                state_n = last_round ? DONE : RUN;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            round   <= 4'd0;
            lat_cnt <= 3'd0;
            cur     <= '0;
            tag     <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur     <= in_state ^ rk_data;
                        tag     <= in_id;
                        round   <= 4'd1;
                        lat_cnt <= 3'd0;
                    end
                end
                RUN: begin
                    if (!last_lat) lat_cnt <= lat_cnt + 3'd1;
                end
                CAP: begin
                    cur <= rnd_result;
                    if (!last_round) begin
                        round   <= round + 4'd1;
                        lat_cnt <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result register loads on the final capture so it already matches cur when DONE begins.
    assign hold_en = (state == CAP) && last_round;

    aes_round_ctrl_floper #(.W(HW)) u_hold (
        .clk (clk),
        .rst (rst),
        .en  (hold_en),
        .d   ({rnd_result, tag}),
        .q   (hold_q)
    );

    assign {out_state, out_id} = hold_q;

`ifdef AES_CTRL_STATS_EN
    logic [31:0] blk_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= 32'd0;
        end else if ((state == DONE) && out_ready && (blk_cnt_q != 32'hFFFF_FFFF)) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl (default and NR=1/RLAT=1 instances)
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    typedef struct packed {
        block_t     st;
        logic [3:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instance A: defaults
    logic       in_valid_a = 1'b0, in_ready_a, rnd_en_a, out_valid_a, busy_a;
    logic       out_ready_a = 1'b1;
    block_t     in_state_a = '0, rk_data_a, rnd_state_a, rnd_key_a, rnd_result_a, out_state_a;
    logic [3:0] in_id_a = '0, rk_idx_a, out_id_a;
    // Instance B: NR=1, RLAT=1
    logic       in_valid_b = 1'b0, in_ready_b, rnd_en_b, out_valid_b, busy_b;
    logic       out_ready_b = 1'b1;
    block_t     in_state_b = '0, rk_data_b, rnd_state_b, rnd_key_b, rnd_result_b, out_state_b;
    logic [3:0] in_id_b = '0, rk_idx_b, out_id_b;
`ifdef AES_CTRL_STATS_EN
    logic [31:0] blk_cnt_a, blk_cnt_b;
`endif

    aes_round_ctrl dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_state(in_state_a), .in_id(in_id_a), .rk_idx(rk_idx_a), .rk_data(rk_data_a),
        .rnd_en(rnd_en_a), .rnd_state(rnd_state_a), .rnd_key(rnd_key_a),
        .rnd_result(rnd_result_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_state(out_state_a), .out_id(out_id_a), .busy(busy_a)
`ifdef AES_CTRL_STATS_EN
        , .blk_cnt(blk_cnt_a)
`endif
    );

    aes_round_ctrl #(.NR(1), .RLAT(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_state(in_state_b), .in_id(in_id_b), .rk_idx(rk_idx_b), .rk_data(rk_data_b),
        .rnd_en(rnd_en_b), .rnd_state(rnd_state_b), .rnd_key(rnd_key_b),
        .rnd_result(rnd_result_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_state(out_state_b), .out_id(out_id_b), .busy(busy_b)
`ifdef AES_CTRL_STATS_EN
        , .blk_cnt(blk_cnt_b)
`endif
    );

    // Stub key store and round units
    assign rk_data_a = {16{{4'h0, rk_idx_a}}};
    assign rk_data_b = {16{{4'h0, rk_idx_b}}};
    block_t pipe_a [2];
    block_t pipe_b;
    always @(posedge clk) begin
        if (rnd_en_a) begin
            pipe_a[0] <= rnd_state_a ^ rnd_key_a;
            pipe_a[1] <= pipe_a[0];
        end
        if (rnd_en_b) pipe_b <= rnd_state_b ^ rnd_key_b;
    end
    assign rnd_result_a = pipe_a[1];
    assign rnd_result_b = pipe_b;

    exp_t exp_q_a[$], exp_q_b[$];
    int   acc_q_a[$], acc_q_b[$];
    int   last_hs_a = -1;
    int   done_a = 0;
    logic prev_v_a = 1'b0, prev_v_b = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            acc_q_a.delete();
            acc_q_b.delete();
            prev_v_a = 1'b0;
            prev_v_b = 1'b0;
            done_a   = 0;
        end else begin
            if (in_valid_a && in_ready_a) begin
                if (last_hs_a >= 0) check("accept_after_handshake", 160'(cyc + 1 > last_hs_a), 160'd1);
                acc_q_a.push_back(cyc + 1);
            end
            if (out_valid_a && !prev_v_a) begin
                if (acc_q_a.size() == 0) check("unexpected_out_valid_a", 160'd1, 160'd0);
                else check("latency_a", 160'(cyc - acc_q_a.pop_front()), 160'd30);
            end
            if (out_valid_a && out_ready_a) begin
                if (exp_q_a.size() == 0) begin
                    check("unexpected_result_a", 160'd1, 160'd0);
                end else begin
                    e = exp_q_a.pop_front();
                    check("out_state_a", 160'(out_state_a), 160'(e.st));
                    check("out_id_a", 160'(out_id_a), 160'(e.id));
                end
                last_hs_a = cyc + 1;
                done_a++;
            end
            prev_v_a = out_valid_a;

            if (in_valid_b && in_ready_b) acc_q_b.push_back(cyc + 1);
            if (out_valid_b && !prev_v_b) begin
                if (acc_q_b.size() == 0) check("unexpected_out_valid_b", 160'd1, 160'd0);
                else check("latency_b", 160'(cyc - acc_q_b.pop_front()), 160'd2);
            end
            if (out_valid_b && out_ready_b) begin
                if (exp_q_b.size() == 0) begin
                    check("unexpected_result_b", 160'd1, 160'd0);
                end else begin
                    e = exp_q_b.pop_front();
                    check("out_state_b", 160'(out_state_b), 160'(e.st));
                    check("out_id_b", 160'(out_id_b), 160'(e.id));
                end
            end
            prev_v_b = out_valid_b;
        end
    end

    task automatic send_a(input block_t s, input logic [3:0] id, input block_t exp_st, input bit push);
        in_state_a = s;
        in_id_a    = id;
        in_valid_a = 1'b1;
        if (push) exp_q_a.push_back({exp_st, id});
        for (int i = 0; i < 400 && !in_ready_a; i++) @(negedge clk);
        check("accept_a", 160'(in_ready_a), 160'd1);
        @(negedge clk);
        in_valid_a = 1'b0;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 400 && (exp_q_a.size() != 0 || busy_a); i++) @(negedge clk);
        check("drain_a", 160'(exp_q_a.size()), 160'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        block_t k0b, v1, v2, v3, v4, vb;
        k0b = {16{8'h0B}};
        v1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        v2  = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        v3  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        v4  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        vb  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

        #1;
        check("rst_in_ready", 160'(in_ready_a), 160'd1);
        check("rst_busy", 160'(busy_a), 160'd0);
        check("rst_out_valid", 160'(out_valid_a), 160'd0);
        check("rst_rnd_en", 160'(rnd_en_a), 160'd0);
        check("rst_rk_idx", 160'(rk_idx_a), 160'd0);
        check("rst_rnd_state", 160'(rnd_state_a), 160'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic block with hand-computed result
        send_a(v1, 4'h5, 128'h0B1A2938_4F5E6D7C_8392A1B0_C7D6E5F4, 1'b1);
        drain_a();

        // Stall in DONE while offering new blocks
        out_ready_a = 1'b0;
        send_a(v2, 4'hA, v2 ^ k0b, 1'b1);
        for (int i = 0; i < 100 && !out_valid_a; i++) @(negedge clk);
        check("stall_reach_done", 160'(out_valid_a), 160'd1);
        for (int i = 0; i < 20; i++) begin
            in_valid_a = 1'b1;
            in_state_a = v3;
            in_id_a    = 4'h7;
            #1;
            check("stall_out_state", 160'(out_state_a), 160'(v2 ^ k0b));
            check("stall_out_id", 160'(out_id_a), 160'hA);
            check("stall_in_ready", 160'(in_ready_a), 160'd0);
            check("stall_out_valid", 160'(out_valid_a), 160'd1);
            check("stall_rnd_state", 160'({rnd_en_a, rnd_state_a, rnd_key_a}), 160'd0);
            @(negedge clk);
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        drain_a();

        // Two blocks in order
        send_a(v3, 4'd3, v3 ^ k0b, 1'b1);
        send_a(v4, 4'd9, v4 ^ k0b, 1'b1);
        drain_a();

        // Reset during round 5
        send_a(v4, 4'hC, '0, 1'b0);
        for (int i = 0; i < 100 && rk_idx_a != 4'd5; i++) @(negedge clk);
        check("reach_round5", 160'(rk_idx_a), 160'd5);
        rst = 1'b1;
        #1;
        check("midrst_busy", 160'(busy_a), 160'd0);
        check("midrst_in_ready", 160'(in_ready_a), 160'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_busy", 160'(busy_a), 160'd0);
        check("postrst_in_ready", 160'(in_ready_a), 160'd1);
        check("postrst_out_valid", 160'(out_valid_a), 160'd0);
        repeat (40) @(negedge clk);
        send_a(v1, 4'h1, v1 ^ k0b, 1'b1);
        drain_a();

        // NR=1, RLAT=1 instance
        in_state_b = vb;
        in_id_b    = 4'h6;
        in_valid_b = 1'b1;
        exp_q_b.push_back({vb ^ {16{8'h01}}, 4'h6});
        @(negedge clk);
        in_valid_b = 1'b0;
        for (int i = 0; i < 50 && (exp_q_b.size() != 0 || busy_b); i++) @(negedge clk);
        check("drain_b", 160'(exp_q_b.size()), 160'd0);

`ifdef AES_CTRL_STATS_EN
        check("blk_cnt", 160'(blk_cnt_a), 160'(done_a));
        send_a(v2, 4'h2, v2 ^ k0b, 1'b1);
        send_a(v3, 4'h4, v3 ^ k0b, 1'b1);
        drain_a();
        check("blk_cnt_3", 160'(blk_cnt_a), 160'd3);
        force dut_a.blk_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut_a.blk_cnt_q;
        send_a(v4, 4'h8, v4 ^ k0b, 1'b1);
        drain_a();
        check("blk_cnt_sat", 160'(blk_cnt_a), 160'hFFFF_FFFF);
`endif

        repeat (3) @(negedge clk);
        check("final_queue_a", 160'(exp_q_a.size()), 160'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
